// File: rtl/ltssm_pkg.sv
// Shared LTSSM substate encoding, LPIF status codes and PIPE width helpers.
// Pure declarations: no latency, no flow control.
package ltssm_pkg;

    typedef enum logic [3:0] {
        DETECT_QUIET        = 4'd0,
        DETECT_ACTIVE       = 4'd1,
        POLLING_ACTIVE      = 4'd2,
        POLLING_CONFIG      = 4'd3,
        CFG_LINKWIDTH_START = 4'd4,
        CFG_LINKWIDTH_ACCEPT= 4'd5,
        CFG_LANENUM_WAIT    = 4'd6,
        CFG_LANENUM_ACCEPT  = 4'd7,
        CFG_COMPLETE        = 4'd8,
        CFG_IDLE            = 4'd9,
        L0                  = 4'd10,
        REC_RCVRLOCK        = 4'd11,
        REC_RCVRCFG         = 4'd12,
        REC_SPEED           = 4'd13,
        REC_IDLE            = 4'd14,
        RESERVED            = 4'd15
    } substate_e;

    localparam logic [3:0] LPIF_RESET   = 4'd0;
    localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
    localparam logic [3:0] LPIF_RETRAIN = 4'd2;

    function automatic logic [1:0] widthCode(input int pipeWidth);
        case (pipeWidth)
            16:      widthCode = 2'd1;
            32:      widthCode = 2'd2;
            default: widthCode = 2'd0;
        endcase
    endfunction

    // The reserved code is never entered; it falls back to DETECT_QUIET.
    function automatic substate_e toSubstate(input logic [3:0] code);
        toSubstate = (code == 4'd15) ? DETECT_QUIET : substate_e'(code);
    endfunction

    function automatic logic [2:0] highestGen(input logic [7:0] rateId);
        highestGen = 3'd1;
        for (int g = 1; g <= 5; g++) begin
            if (rateId[g]) highestGen = 3'(g);
        end
    endfunction

endpackage

// File: rtl/ltssm_link_regs.sv
// Negotiated link parameter registers with port-type link-number echo; clear wins over writes.
// Latency: loads 1 cycle after strobe; no backpressure.
module ltssm_link_regs
    import ltssm_pkg::*;
#(
    parameter int DEVICETYPE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [4:0] numberOfDetectedLanesIn,
    input  logic       writeNumberOfDetectedLanes,
    input  logic [7:0] rateIdIn,
    input  logic       writeRateId,
    input  logic       upConfigureCapabilityIn,
    input  logic       writeUpconfigureCapability,
    input  logic [7:0] linkNumberInTx,
    input  logic       writeLinkNumberTx,
    input  logic [7:0] linkNumberInRx,
    input  logic       writeLinkNumberRx,
    output logic [4:0] numberOfDetectedLanesOut,
    output logic [7:0] rateIdOut,
    output logic       upConfigureCapabilityOut,
    output logic [7:0] linkNumberOutTx,
    output logic [7:0] linkNumberOutRx
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            numberOfDetectedLanesOut <= '0;
            rateIdOut                <= '0;
            upConfigureCapabilityOut <= 1'b0;
            linkNumberOutTx          <= 8'h00;
            linkNumberOutRx          <= 8'h00;
        end else if (clear) begin
            numberOfDetectedLanesOut <= '0;
            rateIdOut                <= '0;
            upConfigureCapabilityOut <= 1'b0;
            linkNumberOutTx          <= 8'h00;
            linkNumberOutRx          <= 8'h00;
        end else begin
            if (writeNumberOfDetectedLanes) numberOfDetectedLanesOut <= numberOfDetectedLanesIn;
            if (writeRateId)                rateIdOut                <= rateIdIn;
            if (writeUpconfigureCapability) upConfigureCapabilityOut <= upConfigureCapabilityIn;
            // A direct write always beats the echo from the other direction.
            if (writeLinkNumberTx)
                linkNumberOutTx <= linkNumberInTx;
            else if (DEVICETYPE == 1 && writeLinkNumberRx)
                linkNumberOutTx <= linkNumberInRx;
            if (writeLinkNumberRx)
                linkNumberOutRx <= linkNumberInRx;
            else if (DEVICETYPE == 0 && writeLinkNumberTx)
                linkNumberOutRx <= linkNumberInTx;
        end
    end

endmodule

// File: rtl/main_ltssm.sv
// PCIe LTSSM sequencer: advances substates on TX/RX finish handshakes, holds link params. Optional SPEED_CHANGE_EN.
// Latency: new substate visible 1 cycle after the completing finish; no backpressure (pulses are sticky).
module main_ltssm
    import ltssm_pkg::*;
#(
    parameter int Width          = 32,
    parameter int DEVICETYPE     = 0,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lpifStateRequest,
    input  logic       forceDetect,
    input  logic       finishTx,
    input  logic       finishRx,
    input  logic [3:0] gotoTx,
    input  logic [3:0] gotoRx,
    input  logic [4:0] numberOfDetectedLanesIn,
    input  logic       writeNumberOfDetectedLanes,
    input  logic [7:0] rateIdIn,
    input  logic       writeRateId,
    input  logic       upConfigureCapabilityIn,
    input  logic       writeUpconfigureCapability,
    input  logic [7:0] linkNumberInTx,
    input  logic [7:0] linkNumberInRx,
    input  logic       writeLinkNumberTx,
    input  logic       writeLinkNumberRx,
    output logic [3:0] substateTx,
    output logic [3:0] substateRx,
    output logic [4:0] numberOfDetectedLanesOut,
    output logic [7:0] rateIdOut,
    output logic       upConfigureCapabilityOut,
    output logic [7:0] linkNumberOutTx,
    output logic [7:0] linkNumberOutRx,
    output logic       linkUp,
    output logic [3:0] lpifStateStatus,
    output logic [2:0] GEN,
    output logic [1:0] width
);

    localparam logic [1:0] WIDTH_GEN1 = widthCode(GEN1_PIPEWIDTH < Width ? GEN1_PIPEWIDTH : Width);
    localparam logic [1:0] WIDTH_GEN2 = widthCode(GEN2_PIPEWIDTH < Width ? GEN2_PIPEWIDTH : Width);
    localparam logic [1:0] WIDTH_GEN3 = widthCode(GEN3_PIPEWIDTH < Width ? GEN3_PIPEWIDTH : Width);
    localparam logic [1:0] WIDTH_GEN4 = widthCode(GEN4_PIPEWIDTH < Width ? GEN4_PIPEWIDTH : Width);
    localparam logic [1:0] WIDTH_GEN5 = widthCode(GEN5_PIPEWIDTH < Width ? GEN5_PIPEWIDTH : Width);

    substate_e  state, nextState;
    logic       advance;
    logic       doneTx, doneRx;
    logic [3:0] heldGotoTx, heldGotoRx;
    logic       txReady, rxReady;
    logic [3:0] effGotoTx, effGotoRx;
    logic       clearRegs;

    assign txReady   = doneTx | finishTx;
    assign rxReady   = doneRx | finishRx;
    assign effGotoTx = finishTx ? gotoTx : heldGotoTx;
    assign effGotoRx = finishRx ? gotoRx : heldGotoRx;

    always_comb begin
        nextState = state;
        advance   = 1'b0;
        if (forceDetect) begin
            nextState = DETECT_QUIET;
            advance   = 1'b1;
        end else if (state == L0) begin
            if (lpifStateRequest == LPIF_RETRAIN) begin
                nextState = REC_RCVRLOCK;
                advance   = 1'b1;
            end else if (finishRx) begin
                nextState = toSubstate(gotoRx);
                advance   = 1'b1;
            end
        end else if (state == DETECT_QUIET || state == DETECT_ACTIVE) begin
            if (txReady) begin
                nextState = toSubstate(effGotoTx);
                advance   = 1'b1;
            end
        end else if (txReady && rxReady) begin
            // Disagreement between the two engines sends the link back to Detect.
            nextState = (effGotoTx == effGotoRx) ? toSubstate(effGotoTx) : DETECT_QUIET;
            advance   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DETECT_QUIET;
            doneTx     <= 1'b0;
            doneRx     <= 1'b0;
            heldGotoTx <= 4'd0;
            heldGotoRx <= 4'd0;
        end else begin
            state <= nextState;
            if (advance) begin
                doneTx <= 1'b0;
                doneRx <= 1'b0;
            end else begin
                if (finishTx) begin
                    doneTx     <= 1'b1;
                    heldGotoTx <= gotoTx;
                end
                if (finishRx) begin
                    doneRx     <= 1'b1;
                    heldGotoRx <= gotoRx;
                end
            end
        end
    end

    assign substateTx      = state;
    assign substateRx      = state;
    assign linkUp          = (state >= L0) && (state <= REC_IDLE);
    assign lpifStateStatus = (state == L0) ? LPIF_ACTIVE :
                             ((state >= REC_RCVRLOCK && state <= REC_IDLE) ? LPIF_RETRAIN : LPIF_RESET);
    assign clearRegs       = (nextState == DETECT_QUIET) && (state != DETECT_QUIET);

`ifdef SPEED_CHANGE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            GEN <= 3'd1;
        else if (state == REC_SPEED && nextState != REC_SPEED)
            GEN <= highestGen(rateIdOut);
    end
`else
    assign GEN = 3'd1;
`endif

    always_comb begin
        case (GEN)
            3'd2:    width = WIDTH_GEN2;
            3'd3:    width = WIDTH_GEN3;
            3'd4:    width = WIDTH_GEN4;
            3'd5:    width = WIDTH_GEN5;
            default: width = WIDTH_GEN1;
        endcase
    end

    ltssm_link_regs #(.DEVICETYPE(DEVICETYPE)) uLinkRegs (
        .clk                        (clk),
        .reset                      (reset),
        .clear                      (clearRegs),
        .numberOfDetectedLanesIn    (numberOfDetectedLanesIn),
        .writeNumberOfDetectedLanes (writeNumberOfDetectedLanes),
        .rateIdIn                   (rateIdIn),
        .writeRateId                (writeRateId),
        .upConfigureCapabilityIn    (upConfigureCapabilityIn),
        .writeUpconfigureCapability (writeUpconfigureCapability),
        .linkNumberInTx             (linkNumberInTx),
        .writeLinkNumberTx          (writeLinkNumberTx),
        .linkNumberInRx             (linkNumberInRx),
        .writeLinkNumberRx          (writeLinkNumberRx),
        .numberOfDetectedLanesOut   (numberOfDetectedLanesOut),
        .rateIdOut                  (rateIdOut),
        .upConfigureCapabilityOut   (upConfigureCapabilityOut),
        .linkNumberOutTx            (linkNumberOutTx),
        .linkNumberOutRx            (linkNumberOutRx)
    );

endmodule

// File: tb/tb_main_ltssm.sv
// Bench for main_ltssm: one downstream-port and one upstream-port instance share the same stimulus.
module tb_main_ltssm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [3:0] lpifStateRequest = 4'd0;
    logic       forceDetect = 1'b0;
    logic       finishTx = 1'b0, finishRx = 1'b0;
    logic [3:0] gotoTx = 4'd0, gotoRx = 4'd0;
    logic [4:0] lanesIn = 5'd0;
    logic       writeLanes = 1'b0;
    logic [7:0] rateIn = 8'd0;
    logic       writeRate = 1'b0;
    logic       upcIn = 1'b0, writeUpc = 1'b0;
    logic [7:0] lnInTx = 8'd0, lnInRx = 8'd0;
    logic       writeLnTx = 1'b0, writeLnRx = 1'b0;

    logic [3:0] subTx0, subRx0, stat0, subTx1, subRx1, stat1;
    logic [4:0] lanes0, lanes1;
    logic [7:0] rate0, rate1, lnTx0, lnRx0, lnTx1, lnRx1;
    logic       upc0, upc1, up0, up1;
    logic [2:0] gen0, gen1;
    logic [1:0] width0, width1;

    main_ltssm #(.DEVICETYPE(0)) dut0 (
        .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest), .forceDetect(forceDetect),
        .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
        .numberOfDetectedLanesIn(lanesIn), .writeNumberOfDetectedLanes(writeLanes),
        .rateIdIn(rateIn), .writeRateId(writeRate),
        .upConfigureCapabilityIn(upcIn), .writeUpconfigureCapability(writeUpc),
        .linkNumberInTx(lnInTx), .linkNumberInRx(lnInRx),
        .writeLinkNumberTx(writeLnTx), .writeLinkNumberRx(writeLnRx),
        .substateTx(subTx0), .substateRx(subRx0), .numberOfDetectedLanesOut(lanes0),
        .rateIdOut(rate0), .upConfigureCapabilityOut(upc0),
        .linkNumberOutTx(lnTx0), .linkNumberOutRx(lnRx0),
        .linkUp(up0), .lpifStateStatus(stat0), .GEN(gen0), .width(width0)
    );

    main_ltssm #(.DEVICETYPE(1)) dut1 (
        .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest), .forceDetect(forceDetect),
        .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
        .numberOfDetectedLanesIn(lanesIn), .writeNumberOfDetectedLanes(writeLanes),
        .rateIdIn(rateIn), .writeRateId(writeRate),
        .upConfigureCapabilityIn(upcIn), .writeUpconfigureCapability(writeUpc),
        .linkNumberInTx(lnInTx), .linkNumberInRx(lnInRx),
        .writeLinkNumberTx(writeLnTx), .writeLinkNumberRx(writeLnRx),
        .substateTx(subTx1), .substateRx(subRx1), .numberOfDetectedLanesOut(lanes1),
        .rateIdOut(rate1), .upConfigureCapabilityOut(upc1),
        .linkNumberOutTx(lnTx1), .linkNumberOutRx(lnRx1),
        .linkUp(up1), .lpifStateStatus(stat1), .GEN(gen1), .width(width1)
    );

    typedef struct {
        logic       fTx;
        logic [3:0] gTx;
        logic       fRx;
        logic [3:0] gRx;
        logic [3:0] req;
        logic       frc;
        logic [3:0] expSub;
        logic       expUp;
        logic [3:0] expStat;
    } vec_t;

    vec_t trainVecs[$];
    vec_t midVecs[$];
    vec_t expQ[$];

    int passCount  = 0;
    int totalCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic fTx, input logic [3:0] gTx, input logic fRx,
                                input logic [3:0] gRx, input logic [3:0] req, input logic frc,
                                input logic [3:0] sub);
        vec_t v;
        v.fTx = fTx; v.gTx = gTx; v.fRx = fRx; v.gRx = gRx; v.req = req; v.frc = frc;
        v.expSub  = sub;
        v.expUp   = (sub >= 4'd10) && (sub <= 4'd14);
        v.expStat = (sub == 4'd10) ? 4'd1 : ((sub >= 4'd11 && sub <= 4'd14) ? 4'd2 : 4'd0);
        return v;
    endfunction

    task automatic idleInputs();
        finishTx = 1'b0; finishRx = 1'b0; gotoTx = 4'd0; gotoRx = 4'd0;
        lpifStateRequest = 4'd0; forceDetect = 1'b0;
        writeLanes = 1'b0; writeRate = 1'b0; writeUpc = 1'b0; writeLnTx = 1'b0; writeLnRx = 1'b0;
    endtask

    task automatic runVecs(input string tag, input vec_t q[$]);
        vec_t e;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            finishTx = q[i].fTx; gotoTx = q[i].gTx; finishRx = q[i].fRx; gotoRx = q[i].gRx;
            lpifStateRequest = q[i].req; forceDetect = q[i].frc;
            expQ.push_back(q[i]);
            @(posedge clk);
            #1;
            e = expQ.pop_front();
            check($sformatf("%s[%0d] substateTx", tag, i), 32'(subTx0), 32'(e.expSub));
            check($sformatf("%s[%0d] substateRx", tag, i), 32'(subRx0), 32'(e.expSub));
            check($sformatf("%s[%0d] linkUp", tag, i), 32'(up0), 32'(e.expUp));
            check($sformatf("%s[%0d] status", tag, i), 32'(stat0), 32'(e.expStat));
            check($sformatf("%s[%0d] dut1 substate", tag, i), 32'(subTx1), 32'(e.expSub));
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic writeRegs(input logic wTx, input logic [7:0] dTx, input logic wRx, input logic [7:0] dRx);
        @(negedge clk);
        writeLnTx = wTx; lnInTx = dTx; writeLnRx = wRx; lnInRx = dRx;
        @(negedge clk);
        writeLnTx = 1'b0; writeLnRx = 1'b0;
    endtask

    initial begin
        // Training table: DQ/DA advance on TX only, sticky finish with RX 3 cycles later, L0 and Recovery.
        trainVecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        trainVecs.push_back(mk(0, 0, 1, 2, 0, 0, 1));
        trainVecs.push_back(mk(1, 2, 0, 0, 0, 0, 2));
        for (int s = 2; s <= 9; s++) begin
            trainVecs.push_back(mk(1, 4'(s + 1), 0, 0, 0, 0, 4'(s)));
            trainVecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'(s)));
            trainVecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'(s)));
            trainVecs.push_back(mk(0, 0, 1, 4'(s + 1), 0, 0, 4'(s + 1)));
        end
        trainVecs.push_back(mk(0, 0, 0, 0, 0, 0, 10));
        trainVecs.push_back(mk(1, 4, 0, 0, 0, 0, 10));
        trainVecs.push_back(mk(0, 0, 1, 11, 0, 0, 11));
        trainVecs.push_back(mk(1, 12, 1, 12, 0, 0, 12));
        trainVecs.push_back(mk(1, 10, 1, 10, 0, 0, 10));
        trainVecs.push_back(mk(0, 0, 1, 0, 2, 0, 11));
        trainVecs.push_back(mk(1, 10, 1, 10, 0, 0, 10));
        trainVecs.push_back(mk(0, 0, 0, 0, 2, 1, 0));
        // Goto mismatch in POLLING_ACTIVE falls back to Detect.
        trainVecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        trainVecs.push_back(mk(1, 2, 0, 0, 0, 0, 2));
        trainVecs.push_back(mk(1, 3, 1, 4, 0, 0, 0));
        // Reserved goto code maps to DETECT_QUIET.
        trainVecs.push_back(mk(1, 15, 0, 0, 0, 0, 0));
        trainVecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        trainVecs.push_back(mk(1, 2, 0, 0, 0, 0, 2));
        trainVecs.push_back(mk(1, 15, 1, 15, 0, 0, 0));
        // Sticky flags must not survive a substate change.
        trainVecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        trainVecs.push_back(mk(1, 2, 0, 0, 0, 0, 2));
        trainVecs.push_back(mk(0, 0, 1, 3, 0, 0, 2));
        trainVecs.push_back(mk(1, 3, 0, 0, 0, 0, 3));
        trainVecs.push_back(mk(1, 4, 0, 0, 0, 0, 3));
        trainVecs.push_back(mk(0, 0, 0, 0, 0, 0, 3));
        trainVecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));

        midVecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        midVecs.push_back(mk(1, 2, 0, 0, 0, 0, 2));
        for (int s = 2; s <= 5; s++)
            midVecs.push_back(mk(1, 4'(s + 1), 1, 4'(s + 1), 0, 0, 4'(s + 1)));

        #3 reset = 1'b0;
        #1;
        check("reset substateTx", 32'(subTx0), 0);
        check("reset substateRx", 32'(subRx0), 0);
        check("reset linkUp", 32'(up0), 0);
        check("reset status", 32'(stat0), 0);
        check("reset GEN", 32'(gen0), 1);
        check("reset width", 32'(width0), 0);
        check("reset lanes", 32'(lanes0), 0);
        check("reset rateId", 32'(rate0), 0);
        check("reset upcfg", 32'(upc0), 0);
        check("reset linkTx", 32'(lnTx0), 0);
        check("reset linkRx", 32'(lnRx0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Link registers while idling in DETECT_QUIET.
        writeRegs(1, 8'h05, 0, 8'h00);
        check("dt0 tx write linkTx", 32'(lnTx0), 32'h05);
        check("dt0 tx write linkRx", 32'(lnRx0), 32'h05);
        check("dt1 tx write linkTx", 32'(lnTx1), 32'h05);
        check("dt1 tx write linkRx", 32'(lnRx1), 32'h00);
        writeRegs(0, 8'h00, 1, 8'h07);
        check("dt1 rx write linkTx", 32'(lnTx1), 32'h07);
        check("dt1 rx write linkRx", 32'(lnRx1), 32'h07);
        check("dt0 rx write linkTx", 32'(lnTx0), 32'h05);
        check("dt0 rx write linkRx", 32'(lnRx0), 32'h07);
        writeRegs(1, 8'h0A, 1, 8'h0B);
        check("dt0 both linkTx", 32'(lnTx0), 32'h0A);
        check("dt0 both linkRx", 32'(lnRx0), 32'h0B);
        check("dt1 both linkTx", 32'(lnTx1), 32'h0A);
        check("dt1 both linkRx", 32'(lnRx1), 32'h0B);
        @(negedge clk);
        lanesIn = 5'd16; writeLanes = 1'b1; rateIn = 8'h06; writeRate = 1'b1; upcIn = 1'b1; writeUpc = 1'b1;
        @(negedge clk);
        idleInputs();
        check("lanes write", 32'(lanes0), 16);
        check("rateId write", 32'(rate0), 32'h06);
        check("upcfg write", 32'(upc0), 1);
        check("substate after writes", 32'(subTx0), 0);

        runVecs("train", trainVecs);
        check("cleared lanes", 32'(lanes0), 0);
        check("cleared rateId", 32'(rate0), 0);
        check("cleared upcfg", 32'(upc0), 0);
        check("cleared linkTx", 32'(lnTx0), 0);
        check("cleared linkRx", 32'(lnRx0), 0);
        check("cleared dt1 linkRx", 32'(lnRx1), 0);

        // Asynchronous reset in CFG_LANENUM_WAIT.
        runVecs("mid", midVecs);
        lanesIn = 5'd5; writeLanes = 1'b1;
        @(negedge clk);
        writeLanes = 1'b0;
        check("mid lanes", 32'(lanes0), 5);
        check("mid linkUp", 32'(up0), 0);
        #2 reset = 1'b0;
        #1;
        check("async substateTx", 32'(subTx0), 0);
        check("async substateRx", 32'(subRx0), 0);
        check("async lanes", 32'(lanes0), 0);
        check("async linkUp", 32'(up0), 0);
        check("async status", 32'(stat0), 0);
        check("async GEN", 32'(gen0), 1);
        check("async width", 32'(width0), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post reset substate", 32'(subTx0), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
